// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Arbitrates data-memory wait, load-use hazard and taken branch by fixed
// priority and drives the PC and pipeline-register write/flush/bubble controls.
// A two-state FSM (RUN / MEM_WAIT) tracks multi-cycle data-memory accesses
// and a saturating wait counter feeds a sticky timeout watchdog.
// Optional feature macro: PIPE_PERF_CNT_EN adds stall_cycles_o / flush_cnt_o.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic [4:0]  ex_rt_i,
  input  logic        ex_memread_i,
  input  logic        branch_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_write_o,
  output logic        idex_bubble_o,
  output logic        exmem_write_o,
  output logic        memwb_bubble_o,
  output logic        mem_timeout_o,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] stall_cycles_o,
  output logic [15:0] flush_cnt_o,
`endif
  output logic        state_o
);

  localparam logic ST_RUN      = 1'b0;
  localparam logic ST_MEM_WAIT = 1'b1;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic             load_use_c;
  logic             mem_stall_c;

  // Hazard decode: load in EX writing a register read by the ID instruction
  always_comb begin
    load_use_c = 1'b0;
    if (ex_memread_i && (ex_rt_i != 5'd0) &&
        ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i))) begin
      load_use_c = 1'b1;
    end
  end

  // Memory stall: a new unacked request in RUN, or no ack yet while waiting
  always_comb begin
    mem_stall_c = 1'b0;
    if (state_q == ST_RUN) begin
      mem_stall_c = mem_req_i && !mem_ack_i;
    end else begin
      mem_stall_c = !mem_ack_i;
    end
  end

  // Control outputs: reset force, then memory stall > load-use > branch
  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_write_o   = 1'b1;
    idex_bubble_o  = 1'b0;
    exmem_write_o  = 1'b1;
    memwb_bubble_o = 1'b0;
    if (rst_i) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      ifid_flush_o   = 1'b1;
      idex_write_o   = 1'b0;
      idex_bubble_o  = 1'b1;
      exmem_write_o  = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (mem_stall_c) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_write_o   = 1'b0;
      exmem_write_o  = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (load_use_c) begin
      // Branch operand is stale under a load-use, so the branch is ignored
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  // Next-state, wait counter and watchdog flag
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          state_d = ST_MEM_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          // Keep waiting forever; the counter only saturates and flags
          if (cnt_q != TIMEOUT_VAL) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (cnt_q == TIMEOUT_VAL) begin
            timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any wait
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign state_o       = state_q;
  assign mem_timeout_o = timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating performance counters for PC stalls and IF/ID flushes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (ifid_flush_o && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_cnt_o    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus random traffic,
// all checked against a behavioural model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

  localparam int unsigned T = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [4:0] id_rs_i = '0, id_rt_i = '0, ex_rt_i = '0;
  logic       ex_memread_i = 1'b0, branch_taken_i = 1'b0;
  logic       mem_req_i = 1'b0, mem_ack_i = 1'b0;
  logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o;
  logic       idex_bubble_o, exmem_write_o, memwb_bubble_o, mem_timeout_o, state_o;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_o;
  logic [15:0] flush_cnt_o;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(10)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .ex_rt_i(ex_rt_i),
    .ex_memread_i(ex_memread_i), .branch_taken_i(branch_taken_i),
    .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
    .idex_write_o(idex_write_o), .idex_bubble_o(idex_bubble_o),
    .exmem_write_o(exmem_write_o), .memwb_bubble_o(memwb_bubble_o),
    .mem_timeout_o(mem_timeout_o),
`ifdef PIPE_PERF_CNT_EN
    .stall_cycles_o(stall_cycles_o), .flush_cnt_o(flush_cnt_o),
`endif
    .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: "waiting" flag, cycles spent waiting, sticky timeout
  bit      m_known = 1'b0;
  bit      m_wait  = 1'b0;
  int      m_k     = 0;
  bit      m_to    = 1'b0;
  longint  m_stall = 0;
  int      m_flush = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, advance the model
  task automatic apply(input logic r, input logic mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic br, input logic rq, input logic ak);
    bit e_pc, e_ifw, e_fl, e_idw, e_bub, e_exw, e_wb, stall_mem, lu;
    @(negedge clk_i);
    rst_i = r; ex_memread_i = mr; ex_rt_i = ert; id_rs_i = rs; id_rt_i = rt;
    branch_taken_i = br; mem_req_i = rq; mem_ack_i = ak;
    #1;
    e_pc = 1; e_ifw = 1; e_fl = 0; e_idw = 1; e_bub = 0; e_exw = 1; e_wb = 0;
    stall_mem = m_wait ? !ak : (rq && !ak);
    lu = mr && (ert != 0) && (ert == rs || ert == rt);
    if (r) begin
      e_pc = 0; e_ifw = 0; e_idw = 0; e_exw = 0; e_fl = 1; e_bub = 1; e_wb = 1;
    end else if (stall_mem) begin
      e_pc = 0; e_ifw = 0; e_idw = 0; e_exw = 0; e_wb = 1;
    end else if (lu) begin
      e_pc = 0; e_ifw = 0; e_bub = 1;
    end else if (br) begin
      e_fl = 1;
    end
    if (m_known) begin
      chk("state_o", 32'(state_o), 32'(m_wait));
      chk("mem_timeout_o", 32'(mem_timeout_o), 32'(m_to));
`ifdef PIPE_PERF_CNT_EN
      chk("stall_cycles_o", stall_cycles_o, 32'(m_stall));
      chk("flush_cnt_o", 32'(flush_cnt_o), 32'(m_flush));
`endif
    end
    chk("pc_write_o", 32'(pc_write_o), 32'(e_pc));
    chk("ifid_write_o", 32'(ifid_write_o), 32'(e_ifw));
    chk("ifid_flush_o", 32'(ifid_flush_o), 32'(e_fl));
    chk("idex_write_o", 32'(idex_write_o), 32'(e_idw));
    chk("idex_bubble_o", 32'(idex_bubble_o), 32'(e_bub));
    chk("exmem_write_o", 32'(exmem_write_o), 32'(e_exw));
    chk("memwb_bubble_o", 32'(memwb_bubble_o), 32'(e_wb));
    if (r) begin
      m_known = 1; m_wait = 0; m_k = 0; m_to = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pc && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (e_fl && m_flush < 16'hFFFF) m_flush++;
      if (!m_wait) begin
        if (rq && !ak) begin m_wait = 1; m_k = 0; end
      end else if (ak) begin
        m_wait = 0;
      end else begin
        m_k++;
        if (m_k >= T) m_to = 1;
      end
    end
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("reset_state", 32'(state_o), 32'd0);

    // Load-use with ex_rt=8 matching rs, then ex_rt=0 (no stall)
    apply(0, 1, 5'd8, 5'd8, 5'd3, 0, 0, 0);
    chk("lu_pc", 32'(pc_write_o), 32'd0);
    chk("lu_bubble", 32'(idex_bubble_o), 32'd1);
    idle();
    chk("lu_release_pc", 32'(pc_write_o), 32'd1);
    apply(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    chk("lu_r0_pc", 32'(pc_write_o), 32'd1);

    // Branch alone, then branch with load-use
    apply(0, 0, 0, 0, 0, 1, 0, 0);
    chk("br_flush", 32'(ifid_flush_o), 32'd1);
    chk("br_pc", 32'(pc_write_o), 32'd1);
    apply(0, 1, 5'd8, 5'd1, 5'd8, 1, 0, 0);
    chk("br_lu_flush", 32'(ifid_flush_o), 32'd0);
    chk("br_lu_pc", 32'(pc_write_o), 32'd0);

    // Memory wait: three unacked wait cycles then ack
    apply(0, 0, 0, 0, 0, 0, 1, 0);
    chk("mw_c1_state", 32'(state_o), 32'd0);
    chk("mw_c1_pc", 32'(pc_write_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 1, 1'($urandom_range(0, 1)), 0);
      chk("mw_wait_state", 32'(state_o), 32'd1);
      chk("mw_wait_wb", 32'(memwb_bubble_o), 32'd1);
    end
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    chk("mw_rel_state", 32'(state_o), 32'd1);
    chk("mw_rel_exmem", 32'(exmem_write_o), 32'd1);
    idle();
    chk("mw_after_state", 32'(state_o), 32'd0);

    // Timeout: ten unacked wait cycles
    apply(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      chk("to_flag", 32'(mem_timeout_o), (i > T) ? 32'd1 : 32'd0);
    end
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    idle();
    chk("to_sticky", 32'(mem_timeout_o), 32'd1);

    // Reset mid-wait (second wait cycle)
    apply(0, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 1, 0);
    apply(1, 1, 5'd8, 5'd8, 0, 1, 1, 0);
    chk("rst_mid_flush", 32'(ifid_flush_o), 32'd1);
    chk("rst_mid_pc", 32'(pc_write_o), 32'd0);
    idle();
    chk("rst_mid_state", 32'(state_o), 32'd0);
    chk("rst_mid_to", 32'(mem_timeout_o), 32'd0);

    // Counter restart after reset: timeout must again take T wait cycles
    apply(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= T + 1; i++) apply(0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 1);

    // Load-use followed by a 4-cycle memory stall, then one branch
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 1, 1);
    idle();
`ifdef PIPE_PERF_CNT_EN
    chk("perf_stall", stall_cycles_o, 32'd5);
    chk("perf_flush0", 32'(flush_cnt_o), 32'd0);
`endif
    apply(0, 0, 0, 0, 0, 1, 0, 0);
    idle();
`ifdef PIPE_PERF_CNT_EN
    chk("perf_flush1", 32'(flush_cnt_o), 32'd1);
`endif

    // Random traffic with small register numbers to force collisions
    for (int n = 0; n < 600; n++) begin
      apply(1'($urandom_range(0, 99) < 3),
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 9) < 3),
            1'($urandom_range(0, 9) < 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
